// File: rtl/pmem_pkg.sv
// pmem_pkg: shared FSM state type, LFSR constants and line index helper for pmem_line_responder
package pmem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} pmem_state_t;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  function automatic logic [31:0] line_index(input logic [63:0] addr, input int unsigned off_w, input int unsigned idx_w);
    return 32'((addr >> off_w) & ((64'd1 << idx_w) - 64'd1));
  endfunction
endpackage

// File: rtl/pmem_lat_lfsr.sv
// pmem_lat_lfsr: free-running 8-bit Fibonacci LFSR supplying 0..7 extra latency cycles
module pmem_lat_lfsr
  import pmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [2:0] extra
);
  logic [7:0] lfsr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  assign extra = lfsr[2:0];
endmodule

// File: rtl/pmem_line_responder.sv
// pmem_line_responder: line-wide memory responder with programmable latency for the L2 miss/write-back port.
// Define PMEM_RANDOM_LATENCY_EN to add 0..7 LFSR-driven extra cycles per request.
module pmem_line_responder
  import pmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_action_stb,
  input  logic              mem_action_cyc,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_resp,
  output logic              mem_retry
);
  localparam int OFFSET_W = $clog2(LINE_W / 8);
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(LATENCY + 8);
  pmem_state_t       state, nxt;
  logic [CNT_W-1:0]  cnt, cnt_n, start;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_rd;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] mem [DEPTH];
  logic              wr_q, req, acc, rd_wr;
`ifdef PMEM_RANDOM_LATENCY_EN
  logic [2:0] extra;
  pmem_lat_lfsr u_lfsr (.clk(clk), .rst_n(rst_n), .extra(extra));
  assign start = CNT_W'(LATENCY - 1) + CNT_W'(extra);
`else
  assign start = CNT_W'(LATENCY - 1);
`endif
  assign req       = mem_action_stb & mem_action_cyc;
  assign idx_d     = IDX_W'(line_index(64'(mem_address), OFFSET_W, IDX_W));
  assign mem_resp  = state == RESP;
  assign mem_retry = req & ~mem_resp;
  always_comb begin
    nxt   = state;
    cnt_n = cnt;
    acc   = 1'b0;
    case (state)
      IDLE: if (req) begin
        acc   = 1'b1;
        cnt_n = start;
        nxt   = start == '0 ? RESP : BUSY;
      end
      BUSY: begin
        cnt_n = cnt - CNT_W'(1);
        nxt   = !req ? IDLE : (cnt == CNT_W'(1) ? RESP : BUSY);
      end
      default: nxt = IDLE;
    endcase
  end
  // a zero-count accept enters RESP straight from IDLE, so the read must use the incoming request
  assign idx_rd = acc ? idx_d : idx_q;
  assign rd_wr  = acc ? mem_write : wr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_rdata <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_n;
      if (nxt == RESP && !rd_wr) mem_rdata <= mem[idx_rd];
    end
  always_ff @(posedge clk) begin
    if (acc) begin
      wr_q    <= mem_write;
      idx_q   <= idx_d;
      wdata_q <= mem_wdata;
    end
    if (state == RESP && wr_q) mem[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_pmem_line_responder.sv
// tb_pmem_line_responder: randomized self-checking bench with a line-array reference model
module tb_pmem_line_responder;
  localparam int L = 4, LW = 256, D = 512;
  logic clk = 0, rst_n = 0, stb = 0, cyc = 0, write = 0;
  logic [31:0] addr = '0;
  logic [LW-1:0] wdata = '0, rdata;
  logic resp, retry;
  int checks = 0, errors = 0;
  logic [LW-1:0] mdl [int];

  pmem_line_responder #(.ADDR_W(32), .LINE_W(LW), .DEPTH(D), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .mem_action_stb(stb), .mem_action_cyc(cyc), .mem_write(write),
    .mem_address(addr), .mem_wdata(wdata), .mem_rdata(rdata), .mem_resp(resp), .mem_retry(retry));

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32) % D);
  endfunction

  function automatic bit lat_ok(input int lat);
`ifdef PMEM_RANDOM_LATENCY_EN
    return lat >= L && lat <= L + 7;
`else
    return lat == L;
`endif
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic xact(input logic wr, input logic [31:0] a, input logic [LW-1:0] d,
                      output int lat, output logic [LW-1:0] rd, output logic retry_bad);
    @(posedge clk); #1;
    stb = 1; cyc = 1; write = wr; addr = a; wdata = d;
    lat = -1; rd = '0; retry_bad = 0;
    for (int k = 0; k < 24; k++) begin
      #1;
      if (resp) begin
        lat = k; rd = rdata;
        if (retry) retry_bad = 1;
        break;
      end else if (!retry) retry_bad = 1;
      @(posedge clk); #1;
    end
    stb = 0; cyc = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (resp !== 1'b0) begin errors++; $display("FAIL reset_resp got %b want 0", resp); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    checks++; if (retry !== 1'b0) begin errors++; $display("FAIL reset_retry got %b want 0", retry); end
    rst_n = 1;
  endtask

  task automatic test_write_read();
    int lat; logic [LW-1:0] rd, d; logic rb;
    d = {8{32'hDEADBEEF}};
    xact(1, 32'h1000, d, lat, rd, rb);
    mdl[idx_of(32'h1000)] = d;
    checks++; if (!lat_ok(lat)) begin errors++; $display("FAIL wr_latency got %0d want %0d", lat, L); end
    checks++; if (rb) begin errors++; $display("FAIL wr_retry got bad want clean"); end
    xact(0, 32'h1000, '0, lat, rd, rb);
    checks++; if (!lat_ok(lat)) begin errors++; $display("FAIL rd_latency got %0d want %0d", lat, L); end
    checks++; if (rd !== d) begin errors++; $display("FAIL rd_data got %h want %h", rd, d); end
    checks++; if (rb) begin errors++; $display("FAIL rd_retry got bad want clean"); end
  endtask

  task automatic test_retry();
    @(posedge clk); #1;
    stb = 1; cyc = 0; #1;
    checks++; if (retry !== 1'b0) begin errors++; $display("FAIL retry_nocyc got %b want 0", retry); end
    stb = 0; cyc = 1; #1;
    checks++; if (retry !== 1'b0) begin errors++; $display("FAIL retry_nostb got %b want 0", retry); end
    stb = 1; #1;
    checks++; if (retry !== 1'b1) begin errors++; $display("FAIL retry_req got %b want 1", retry); end
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #2;
      if (resp) break;
    end
    stb = 0; cyc = 0;
  endtask

  task automatic test_abort();
    int lat; logic [LW-1:0] rd, oldd, newd; logic rb, seen;
    oldd = rnd_line(); newd = ~oldd;
    xact(1, 32'h2040, oldd, lat, rd, rb);
    mdl[idx_of(32'h2040)] = oldd;
    @(posedge clk); #1;
    stb = 1; cyc = 1; write = 1; addr = 32'h2040; wdata = newd;
    @(posedge clk); #1;
    @(posedge clk); #1;
    stb = 0;
    seen = 0;
    repeat (12) begin
      #1; if (resp) seen = 1;
      @(posedge clk); #1;
    end
    cyc = 0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_resp got %b want 0", seen); end
    xact(0, 32'h2040, '0, lat, rd, rb);
    checks++; if (rd !== oldd) begin errors++; $display("FAIL abort_data got %h want %h", rd, oldd); end
    checks++; if (!lat_ok(lat)) begin errors++; $display("FAIL abort_next_latency got %0d want %0d", lat, L); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [LW-1:0] rd, oldd, newd; logic rb;
    oldd = rnd_line(); newd = rnd_line() | 1;
    if (newd == oldd) newd = ~oldd;
    xact(1, 32'h3100, oldd, lat, rd, rb);
    mdl[idx_of(32'h3100)] = oldd;
    xact(0, 32'h3100, '0, lat, rd, rb);
    @(posedge clk); #1;
    stb = 1; cyc = 1; write = 1; addr = 32'h3100; wdata = newd;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0; #1;
    checks++; if (rdata !== '0) begin errors++; $display("FAIL midrst_rdata got %h want 0", rdata); end
    @(posedge clk); #1;
    checks++; if (resp !== 1'b0) begin errors++; $display("FAIL midrst_resp got %b want 0", resp); end
    stb = 0; cyc = 0; rst_n = 1;
    xact(0, 32'h3100, '0, lat, rd, rb);
    checks++; if (rd !== oldd) begin errors++; $display("FAIL midrst_data got %h want %h", rd, oldd); end
  endtask

  task automatic test_alias();
    int lat; logic [LW-1:0] rd, a, z; logic rb;
    a = rnd_line(); z = rnd_line();
    xact(1, 32'h0000, z, lat, rd, rb); mdl[idx_of(32'h0)] = z;
    xact(1, 32'h3FE0, a, lat, rd, rb); mdl[idx_of(32'h3FE0)] = a;
    xact(0, 32'h3FE0 + D * 32, '0, lat, rd, rb);
    checks++; if (rd !== mdl[idx_of(32'h3FE0 + D * 32)]) begin errors++; $display("FAIL alias_data got %h want %h", rd, a); end
    xact(0, 32'h0000, '0, lat, rd, rb);
    checks++; if (rd !== z) begin errors++; $display("FAIL index0_data got %h want %h", rd, z); end
  endtask

  task automatic test_back_to_back();
    int t[$]; int sp;
    @(posedge clk); #1;
    stb = 1; cyc = 1; write = 0; addr = 32'h1000;
    for (int k = 0; k < 60 && t.size() < 3; k++) begin
      #1;
      if (resp) begin
        t.push_back(k);
        checks++; if (rdata !== mdl[idx_of(32'h1000)]) begin errors++; $display("FAIL b2b_data got %h want %h", rdata, mdl[idx_of(32'h1000)]); end
      end
      @(posedge clk); #1;
    end
    stb = 0; cyc = 0;
    checks++; if (t.size() != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", t.size()); end
    for (int i = 1; i < t.size(); i++) begin
      sp = t[i] - t[i-1];
      checks++; if (!lat_ok(sp - 1)) begin errors++; $display("FAIL b2b_spacing got %0d want %0d", sp, L + 1); end
    end
  endtask

  task automatic test_random();
    int lat; logic [LW-1:0] rd, d; logic rb, wr; logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom);
      a = (n % 4 == 0) ? 32'h1000 + ($urandom_range(0, 3) << 14) : $urandom;
      d = rnd_line();
      xact(wr, a, d, lat, rd, rb);
      checks++; if (!lat_ok(lat) || rb) begin errors++; $display("FAIL rand_handshake got lat %0d retrybad %b want lat %0d", lat, rb, L); end
      if (wr) mdl[idx_of(a)] = d;
      else if (mdl.exists(idx_of(a))) begin
        checks++; if (rd !== mdl[idx_of(a)]) begin errors++; $display("FAIL rand_data got %h want %h", rd, mdl[idx_of(a)]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_retry();
    test_abort();
    test_reset_mid();
    test_alias();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
